// File: rtl/sprite_layer_ctrl_if.sv
// Pixel-rate bundle between the sprite ROM bank, game logic and the sprite compositor.
// Inputs are sampled every pixel clock; there is no valid/ready handshake (frame_tick/flash_req are single-cycle pulses).
interface sprite_layer_ctrl_if #(
  parameter int N_LAYERS = 4
);
  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  logic                    frame_tick;
  logic [N_LAYERS-1:0]     layer_en;
  logic [N_LAYERS-1:0]     flash_req;
  logic [N_LAYERS-1:0]     layer_visible;
  logic [24*N_LAYERS-1:0]  layer_rgb;
  logic [7:0]              R;
  logic [7:0]              G;
  logic [7:0]              B;
  logic                    visible;
  logic [IDX_W-1:0]        win_idx;
  logic [N_LAYERS-1:0]     flashing;
  // Debug view of each blink sequencer, 2 bits per layer (0 idle, 1 hide, 2 show)
  logic [2*N_LAYERS-1:0]   seq_state;

  modport master (
    output frame_tick, layer_en, flash_req, layer_visible, layer_rgb,
    input  R, G, B, visible, win_idx, flashing, seq_state
  );

  modport slave (
    input  frame_tick, layer_en, flash_req, layer_visible, layer_rgb,
    output R, G, B, visible, win_idx, flashing, seq_state
  );
endinterface

// File: rtl/sprite_layer_ctrl.sv
// Fixed-priority sprite compositor with colour-key transparency and per-layer
// frame-counted blink sequencers; composited pixel is registered once.
module sprite_layer_ctrl #(
  parameter int          N_LAYERS     = 4,
  parameter int          BLINK_FRAMES = 15,
  parameter int          FLASH_COUNT  = 3,
  parameter bit          KEY_EN       = 1'b1,
  parameter logic [23:0] BG_RGB       = 24'h000000
) (
  input logic                clk,
  input logic                rst_n,
  sprite_layer_ctrl_if.slave bus
);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int REM_W = $clog2(FLASH_COUNT + 1);
  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(FLASH_COUNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIDE = 2'd1,
    S_SHOW = 2'd2
  } seq_state_t;

  seq_state_t       state_q [N_LAYERS];
  seq_state_t       state_d [N_LAYERS];
  logic [FC_W-1:0]  cnt_q   [N_LAYERS];
  logic [FC_W-1:0]  cnt_d   [N_LAYERS];
  logic [REM_W-1:0] rem_q   [N_LAYERS];
  logic [REM_W-1:0] rem_d   [N_LAYERS];

  logic [N_LAYERS-1:0] eligible;
  logic                hit;
  logic [IDX_W-1:0]    win;
  logic [23:0]         pix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LAYERS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_LAYERS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  // Disable beats a request, and a request beats a coincident frame tick.
  always_comb begin
    for (int i = 0; i < N_LAYERS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rem_d[i]   = rem_q[i];
      if (!bus.layer_en[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        rem_d[i]   = '0;
      end else if (bus.flash_req[i]) begin
        state_d[i] = S_HIDE;
        cnt_d[i]   = '0;
        rem_d[i]   = REM_INIT;
      end else if (bus.frame_tick) begin
        case (state_q[i])
          S_HIDE: begin
            if (cnt_q[i] == FC_LAST) begin
              cnt_d[i]   = '0;
              rem_d[i]   = rem_q[i] - REM_W'(1);
              state_d[i] = (rem_q[i] > REM_W'(1)) ? S_SHOW : S_IDLE;
            end else begin
              cnt_d[i] = cnt_q[i] + FC_W'(1);
            end
          end
          S_SHOW: begin
            if (cnt_q[i] == FC_LAST) begin
              cnt_d[i]   = '0;
              state_d[i] = S_HIDE;
            end else begin
              cnt_d[i] = cnt_q[i] + FC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Descending scan so the lowest eligible index is the last (winning) assignment.
  always_comb begin
    eligible = '0;
    hit      = 1'b0;
    win      = '0;
    pix      = BG_RGB;
    for (int i = 0; i < N_LAYERS; i++) begin
      eligible[i] = bus.layer_en[i] && bus.layer_visible[i] && (state_q[i] != S_HIDE) &&
                    (!KEY_EN || (bus.layer_rgb[24*i +: 24] != 24'h000000));
    end
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        hit = 1'b1;
        win = IDX_W'(i);
        pix = bus.layer_rgb[24*i +: 24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.R       <= BG_RGB[23:16];
      bus.G       <= BG_RGB[15:8];
      bus.B       <= BG_RGB[7:0];
      bus.visible <= 1'b0;
      bus.win_idx <= '0;
    end else begin
      bus.R       <= pix[23:16];
      bus.G       <= pix[15:8];
      bus.B       <= pix[7:0];
      bus.visible <= hit;
      bus.win_idx <= win;
    end
  end

  always_comb begin
    bus.flashing  = '0;
    bus.seq_state = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      bus.flashing[i]         = (state_q[i] != S_IDLE);
      bus.seq_state[2*i +: 2] = state_q[i];
    end
  end
endmodule
